systolic_array_ctrl: RTL and testbench

//  Sequencer for the weight-stationary systolic_array datapath. On start it loads one ARRAY_M x ARRAY_N

---
 rtl/systolic_ctrl_pkg.sv | 20 ++
 rtl/sa_ctrl_delay_line.sv | 38 +++
 rtl/systolic_array_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// Optional performance counters are enabled with SYSTOLIC_CTRL_PERF_CNT_EN.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadWgt,
        StLatch,
        StStream,
        StDrain
    } state_e;

    localparam int unsigned PERF_W = 32;

    // Counter width able to hold 0..m inclusive.
    function automatic int unsigned cnt_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sa_ctrl_delay_line.sv
// Reset-clearable shift register exposing every tap; bit 0 of each word is its valid flag,
// and any_valid_o reports whether any tap currently holds a valid word.
module sa_ctrl_delay_line
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [WIDTH-1:0]             in_i,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps_o,
    output logic                         any_valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= in_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            any_valid_o = any_valid_o | sr_q[i][0];
        end
    end

    assign taps_o = sr_q;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight tile load, latch, input stream, drain.
// Define SYSTOLIC_CTRL_PERF_CNT_EN to add the perf_cycles_o / perf_beats_o counters.
module systolic_array_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned ARRAY_M    = 32,
    parameter int unsigned ARRAY_N    = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROWS_WIDTH = 16,
    parameter int unsigned OUT_LAT    = ARRAY_M + ARRAY_N
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ROWS_WIDTH-1:0] num_rows_i,
    input  logic [ADDR_WIDTH-1:0] wgt_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] inp_base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wgt_rd_en_o,
    output logic [ADDR_WIDTH-1:0] wgt_rd_addr_o,
    output logic                  inp_rd_en_o,
    output logic [ADDR_WIDTH-1:0] inp_rd_addr_o,
    output logic [ARRAY_N-1:0]    b_path_en_o,
    output logic [ARRAY_N-1:0]    b_en_o,
    output logic [ARRAY_M-1:0]    a_skew_en_o,
    output logic                  out_valid_o,
    output logic                  out_last_o
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     perf_cycles_o,
    output logic [PERF_W-1:0]     perf_beats_o
`endif
);

    localparam int unsigned CNT_W = cnt_width(ARRAY_M);

    state_e                state_q;
    logic                  busy_q, done_q;
    logic                  wgt_rd_en_q, inp_rd_en_q, inp_last_q;
    logic                  b_path_q, b_en_q;
    logic [ADDR_WIDTH-1:0] wgt_addr_q, inp_addr_q, inp_base_q;
    logic [ROWS_WIDTH-1:0] rows_q, row_cnt_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  accept;

    logic [ARRAY_M-1:0][0:0] skew_taps;
    logic [OUT_LAT-1:0][1:0] out_taps;
    logic                    skew_any, out_any, out_pending;

    assign accept = (state_q == StIdle) && start_i && !busy_q;

    sa_ctrl_delay_line #(
        .DEPTH(ARRAY_M),
        .WIDTH(1)
    ) u_skew (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_i       (inp_rd_en_q),
        .taps_o     (skew_taps),
        .any_valid_o(skew_any)
    );

    sa_ctrl_delay_line #(
        .DEPTH(OUT_LAT),
        .WIDTH(2)
    ) u_out (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_i       ({inp_last_q, inp_rd_en_q}),
        .taps_o     (out_taps),
        .any_valid_o(out_any)
    );

    // Once only the output tap is occupied, the beat leaving now is the final one.
    assign out_pending = |out_taps[OUT_LAT-2:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wgt_rd_en_q <= 1'b0;
            inp_rd_en_q <= 1'b0;
            inp_last_q  <= 1'b0;
            b_path_q    <= 1'b0;
            b_en_q      <= 1'b0;
            wgt_addr_q  <= '0;
            inp_addr_q  <= '0;
            inp_base_q  <= '0;
            rows_q      <= '0;
            row_cnt_q   <= '0;
            cnt_q       <= '0;
        end else begin
            done_q   <= 1'b0;
            b_path_q <= wgt_rd_en_q;
            // Weight latch fires on the cycle after the final shift beat.
            b_en_q   <= b_path_q & ~wgt_rd_en_q;
            if (done_q) busy_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        busy_q      <= 1'b1;
                        rows_q      <= num_rows_i;
                        inp_base_q  <= inp_base_addr_i;
                        wgt_addr_q  <= wgt_base_addr_i;
                        wgt_rd_en_q <= 1'b1;
                        cnt_q       <= CNT_W'(1);
                        state_q     <= StLoadWgt;
                    end
                end
                StLoadWgt: begin
                    if (!wgt_rd_en_q) begin
                        state_q <= StLatch;
                    end else if (cnt_q == CNT_W'(ARRAY_M)) begin
                        wgt_rd_en_q <= 1'b0;
                    end else begin
                        wgt_addr_q <= wgt_addr_q + ADDR_WIDTH'(1);
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                StLatch: begin
                    if (rows_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        inp_rd_en_q <= 1'b1;
                        inp_addr_q  <= inp_base_q;
                        row_cnt_q   <= ROWS_WIDTH'(1);
                        inp_last_q  <= (rows_q == ROWS_WIDTH'(1));
                        state_q     <= StStream;
                    end
                end
                StStream: begin
                    if (row_cnt_q == rows_q) begin
                        inp_rd_en_q <= 1'b0;
                        inp_last_q  <= 1'b0;
                        state_q     <= StDrain;
                    end else begin
                        inp_addr_q <= inp_addr_q + ADDR_WIDTH'(1);
                        row_cnt_q  <= row_cnt_q + ROWS_WIDTH'(1);
                        inp_last_q <= (row_cnt_q + ROWS_WIDTH'(1) == rows_q);
                    end
                end
                StDrain: begin
                    if (out_any && !out_pending && !skew_any) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cycles_q, perf_beats_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_q <= '0;
            perf_beats_q  <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_beats_q  <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 1'b1;
            if (out_valid_o && (perf_beats_q != '1)) perf_beats_q <= perf_beats_q + 1'b1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_beats_o  = perf_beats_q;
`endif

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wgt_rd_en_o   = wgt_rd_en_q;
    assign wgt_rd_addr_o = wgt_addr_q;
    assign inp_rd_en_o   = inp_rd_en_q;
    assign inp_rd_addr_o = inp_addr_q;
    assign b_path_en_o   = {ARRAY_N{b_path_q}};
    assign b_en_o        = {ARRAY_N{b_en_q}};
    assign a_skew_en_o   = skew_taps;
    assign out_valid_o   = out_taps[OUT_LAT-1][0];
    assign out_last_o    = out_taps[OUT_LAT-1][1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: table jobs, random jobs, held start, mid-job reset.
// Perf counter checks are compiled in when SYSTOLIC_CTRL_PERF_CNT_EN is defined.
module tb_systolic_array_ctrl;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int OL = M + N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  num_rows;
    logic [9:0]   wgt_base, inp_base;
    logic         busy, done, wgt_rd_en, inp_rd_en, out_valid, out_last;
    logic [9:0]   wgt_rd_addr, inp_rd_addr;
    logic [N-1:0] b_path_en, b_en;
    logic [M-1:0] a_skew_en;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [31:0]  perf_cycles, perf_beats;
`endif

    int nvec  = 0;
    int nfail = 0;

    systolic_array_ctrl #(
        .ARRAY_M   (M),
        .ARRAY_N   (N),
        .ADDR_WIDTH(10),
        .ROWS_WIDTH(16),
        .OUT_LAT   (OL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .num_rows_i     (num_rows),
        .wgt_base_addr_i(wgt_base),
        .inp_base_addr_i(inp_base),
        .busy_o         (busy),
        .done_o         (done),
        .wgt_rd_en_o    (wgt_rd_en),
        .wgt_rd_addr_o  (wgt_rd_addr),
        .inp_rd_en_o    (inp_rd_en),
        .inp_rd_addr_o  (inp_rd_addr),
        .b_path_en_o    (b_path_en),
        .b_en_o         (b_en),
        .a_skew_en_o    (a_skew_en),
        .out_valid_o    (out_valid),
        .out_last_o     (out_last)
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
        ,
        .perf_cycles_o  (perf_cycles),
        .perf_beats_o   (perf_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rows;
        logic [9:0] wb;
        logic [9:0] ib;
        int         lat;   // expected start-to-done latency
    } vec_t;

    // Input reads occupy cycles M+2 .. M+1+R after acceptance.
    function automatic bit ien_at(input int c, input int r);
        return (r > 0) && (c >= M + 2) && (c <= M + 1 + r);
    endfunction

    function automatic int done_cycle(input int r);
        return (r > 0) ? (M + 2 + r + OL) : (M + 2);
    endfunction

    function automatic logic [37:0] model(input int c, input int r,
                                          input logic [9:0] wb, input logic [9:0] ib);
        logic         e_busy, e_done, e_wen, e_ien, e_bp, e_be, e_ov, e_ol;
        logic [9:0]   e_wa, e_ia;
        logic [M-1:0] e_skew;
        int           d;
        d      = done_cycle(r);
        e_busy = (c >= 0) && (c <= d);
        e_done = (c == d);
        e_wen  = (c >= 0) && (c <= M - 1);
        e_wa   = e_wen ? 10'(wb + 10'(c)) : 10'h0;
        e_ien  = ien_at(c, r);
        e_ia   = e_ien ? 10'(ib + 10'(c - (M + 2))) : 10'h0;
        e_bp   = (c >= 1) && (c <= M);
        e_be   = (c == M + 1);
        for (int k = 0; k < M; k++) e_skew[k] = ien_at(c - k - 1, r);
        e_ov   = ien_at(c - OL, r);
        e_ol   = (r > 0) && (c == M + 1 + r + OL);
        return {e_busy, e_done, e_wen, e_wa, e_ien, e_ia, {N{e_bp}}, {N{e_be}}, e_skew, e_ov, e_ol};
    endfunction

    task automatic start_job(input int r, input logic [9:0] wb, input logic [9:0] ib,
                             input bit hold);
        num_rows = 16'(r);
        wgt_base = wb;
        inp_base = ib;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Checks cycles 0..min(upto, done+1) of a job accepted at the preceding clock edge.
    task automatic check_job(input int r, input logic [9:0] wb, input logic [9:0] ib,
                             input int upto, input int exp_lat);
        int          d, done_at;
        logic [37:0] exp_v, act_v;
        d       = done_cycle(r);
        done_at = -1;
        for (int c = 0; (c <= upto) && (c <= d + 1); c++) begin
            @(negedge clk);
            exp_v = model(c, r, wb, ib);
            act_v = {busy, done, wgt_rd_en, (exp_v[35] ? wgt_rd_addr : 10'h0),
                     inp_rd_en, (exp_v[24] ? inp_rd_addr : 10'h0),
                     b_path_en, b_en, a_skew_en, out_valid, out_last};
            nvec++;
            if (act_v !== exp_v || (b_en & b_path_en) != '0 || (wgt_rd_en & inp_rd_en)) begin
                nfail++;
                $display("FAIL trace r=%0d cycle=%0d actual=%h required=%h", r, c, act_v, exp_v);
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
            if (c == d + 1) begin
                nvec++;
                if (perf_cycles !== 32'(d + 1) || perf_beats !== 32'(r)) begin
                    nfail++;
                    $display("FAIL perf r=%0d actual cycles=%0d beats=%0d required cycles=%0d beats=%0d",
                             r, perf_cycles, perf_beats, d + 1, r);
                end
            end
`endif
        end
        if (exp_lat > 0 && upto > d) begin
            nvec++;
            if (done_at + 1 != exp_lat) begin
                nfail++;
                $display("FAIL latency r=%0d actual=%0d required=%0d", r, done_at + 1, exp_lat);
            end
        end
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{rows: 3, wb: 10'h008, ib: 10'h3FE, lat: 18};
        tbl[1] = '{rows: 0, wb: 10'h005, ib: 10'h000, lat: 7};
        tbl[2] = '{rows: 1, wb: 10'h3FF, ib: 10'h010, lat: 16};
        tbl[3] = '{rows: 5, wb: 10'h100, ib: 10'h200, lat: 20};
        tbl[4] = '{rows: 9, wb: 10'h000, ib: 10'h3F8, lat: 24};

        rst_n    = 1'b0;
        start    = 1'b0;
        num_rows = '0;
        wgt_base = '0;
        inp_base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({busy, done, wgt_rd_en, inp_rd_en, b_path_en, b_en, a_skew_en, out_valid, out_last} !== '0) begin
            nfail++;
            $display("FAIL reset_state actual busy=%b done=%b required all zero", busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            start_job(tbl[i].rows, tbl[i].wb, tbl[i].ib, 1'b0);
            check_job(tbl[i].rows, tbl[i].wb, tbl[i].ib, 1000, tbl[i].lat);
        end

        for (int k = 0; k < 6; k++) begin
            int         r;
            logic [9:0] wb, ib;
            r  = int'($urandom_range(0, 12));
            wb = 10'($urandom);
            ib = (k % 2 == 0) ? 10'($urandom_range(1015, 1023)) : 10'($urandom);
            start_job(r, wb, ib, 1'b0);
            check_job(r, wb, ib, 1000, (r > 0) ? (15 + r) : 7);
        end

        // start held high through a job and past done: exactly one re-acceptance.
        start_job(2, 10'h020, 10'h040, 1'b1);
        check_job(2, 10'h020, 10'h040, 1000, 17);
        @(posedge clk);
        #1 start = 1'b0;
        check_job(2, 10'h020, 10'h040, 1000, 17);

        // Reset in the middle of the input stream.
        start_job(6, 10'h0A0, 10'h0B0, 1'b0);
        check_job(6, 10'h0A0, 10'h0B0, M + 4, 0);
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, wgt_rd_en, inp_rd_en, b_path_en, b_en, a_skew_en, out_valid, out_last} !== '0) begin
            nfail++;
            $display("FAIL async_reset actual busy=%b inp_rd_en=%b required zero", busy, inp_rd_en);
        end
        repeat (2) begin
            @(negedge clk);
            nvec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nfail++;
                $display("FAIL reset_hold actual done=%b busy=%b required 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_job(4, 10'h3FD, 10'h3FE, 1'b0);
        check_job(4, 10'h3FD, 10'h3FE, 1000, 19);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
